axi4_boot_ctrl: RTL and testbench
=================================

AXI4_BOOT_CTRL -- requirements
Module: axi4_boot_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 512: AXI write data width; only bits [63:0] are decoded.
REQ-002 Parameter ADDR_WIDTH, default 64: AXI address width.
REQ-003 Parameter ID_WIDTH, default 4: AXI ID width.
REQ-004 Parameter RST_CYCLES, default 16: number of cycles core reset is held after a start command.
REQ-005 Parameter TIMEOUT_CYCLES, default 1048576: maximum number of RUN cycles before a forced stop.
REQ-006 aclk  in  1  single clock; all logic is rising-edge.
REQ-007 areset  in  1  asynchronous, active-high reset.
REQ-008 s_axi_awid/awaddr/awvalid  in  ID_WIDTH/ADDR_WIDTH/1  AXI write-address channel; s_axi_awready  out  1.
REQ-009 s_axi_wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  AXI write-data channel (single-beat); s_axi_wready  out  1.
REQ-010 s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1; s_axi_bready  in  1  AXI write-response channel.
REQ-011 core_done_i  in  1  core reports program completion.
REQ-012 core_rst_o  out  1  active-high core reset.
REQ-013 fetch_en_o  out  1  core fetch enable.
REQ-014 boot_addr_o  out  64  core boot address.
REQ-015 busy_o / done_o / timeout_o  out  1 each  status flags.

Function
REQ-016 awready and wready SHALL both equal (awvalid & wvalid & !bvalid); AW and W are accepted in the same cycle, with one outstanding transaction maximum.
REQ-017 bvalid SHALL assert the cycle after acceptance and hold with stable bid (= accepted awid) and bresp until bready is sampled high.
REQ-018 Register map (exact awaddr match): 0x00 CMD, 0x08 BOOT_ADDR, 0x10 ABORT; any other address gives SLVERR (2'b10) with no effect.
REQ-019 CMD write of wdata[63:0]=64'hFFFF_FFFF_FFFF_FFFF with wstrb[7:0]=8'hFF while in IDLE or DONE SHALL start a boot and return OKAY; any other CMD write returns OKAY with no effect.
REQ-020 A CMD start or BOOT_ADDR write while busy_o=1 SHALL return SLVERR and be ignored.
REQ-021 A BOOT_ADDR write when not busy SHALL latch wdata[63:0] into boot_addr_o on the following cycle; boot_addr_o is otherwise stable.
REQ-022 An ABORT write (any data) SHALL force IDLE on the next cycle from any state, clear all counters and return OKAY.
REQ-023 FSM states: IDLE, RST_HOLD, RUN, DONE.
REQ-024 IDLE: core_rst_o=1, fetch_en_o=0, busy_o=0; a start moves to RST_HOLD and clears done_o and timeout_o.
REQ-025 RST_HOLD: core_rst_o=1, busy_o=1; after exactly RST_CYCLES cycles in the state, move to RUN.
REQ-026 RUN: core_rst_o=0, fetch_en_o=1, busy_o=1; a cycle counter starts at 0 on entry.
REQ-027 RUN: core_done_i=1 moves to DONE and sets done_o=1.
REQ-028 RUN: when the counter reaches TIMEOUT_CYCLES-1 without core_done_i, move to DONE and set done_o=1 and timeout_o=1.
REQ-029 If core_done_i and the timeout coincide, core_done_i wins and timeout_o stays 0.
REQ-030 DONE: core_rst_o=1, fetch_en_o=0, busy_o=0; done_o and timeout_o are sticky until the next start or ABORT; a start re-enters RST_HOLD.
REQ-031 core_done_i SHALL be ignored outside RUN.
REQ-032 Counters SHALL be sized $clog2(max(RST_CYCLES, TIMEOUT_CYCLES))+1 bits and SHALL never wrap.

Reset
REQ-033 areset SHALL force state IDLE, all counters 0, awready=wready=bvalid=0, bresp=0, bid=0, core_rst_o=1, fetch_en_o=0, boot_addr_o=0, busy_o=done_o=timeout_o=0.
REQ-034 Reset asserted mid-transaction SHALL drop a pending bvalid with no response; reset asserted in RUN SHALL reassert core_rst_o immediately (asynchronously).

Structure
REQ-035 Register offsets, the start magic value, bresp codes and the FSM state enum SHALL live in the shared package boot_pkg.
REQ-036 The AXI write front-end SHALL be one sub-module, axi4_boot_wr_if, which outputs a one-cycle register-write strobe (address, data, strobe) and accepts an error flag back for bresp.

Verification
REQ-037 Write 0x08 = 0x8000_0000, then 0x00 = all-ones -> both bresp OKAY; core_rst_o low exactly 16 cycles after the start acceptance; fetch_en_o=1; boot_addr_o=0x8000_0000.
REQ-038 In RUN, pulse core_done_i after 50 cycles -> DONE next cycle, done_o=1, timeout_o=0, core_rst_o=1.
REQ-039 TIMEOUT_CYCLES=32, no core_done_i -> DONE after 32 RUN cycles, timeout_o=1; core_done_i asserted on cycle 32 instead -> timeout_o=0.
REQ-040 Start while in RUN -> SLVERR; state unchanged; write to 0x18 -> SLVERR.
REQ-041 Hold bready low for 10 cycles -> bvalid/bid held stable; awready=0 throughout; ABORT in RST_HOLD -> IDLE next cycle.
REQ-042 Assert areset in RUN -> core_rst_o=1 the same cycle; all outputs at their reset values.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot controller: register map, start magic,
// AXI response codes and the sequencing state enum.
package boot_pkg;

  localparam logic [63:0] REG_CMD       = 64'h00;
  localparam logic [63:0] REG_BOOT_ADDR = 64'h08;
  localparam logic [63:0] REG_ABORT     = 64'h10;

  localparam logic [63:0] START_MAGIC = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [7:0]  START_STRB  = 8'hFF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE
  } boot_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_boot_ctrl_if.sv
// AXI4 write-only slave bundle (AW, W, B) used by the boot controller.
interface axi4_boot_ctrl_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) ();

  logic [ID_WIDTH-1:0]     s_axi_awid;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid
  );

endinterface

// File: rtl/axi4_boot_wr_if.sv
// Single-beat AXI write front-end: joint AW/W acceptance, one outstanding
// transaction, one-cycle register-write strobe out, error flag in for bresp.
module axi4_boot_wr_if
  import boot_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi4_boot_ctrl_if.slave       s_axi,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [63:0]           o_wr_data,
  output logic [7:0]            o_wr_strb,
  input  logic                  i_wr_err
);

  logic                r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_bresp;
  logic                w_accept;
  logic                w_unused_bits;

  // Ready is held low during reset even though bvalid is already clear.
  assign w_accept = s_axi.s_axi_awvalid & s_axi.s_axi_wvalid & ~r_bvalid & ~areset;

  assign s_axi.s_axi_awready = w_accept;
  assign s_axi.s_axi_wready  = w_accept;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bid     = r_bid;
  assign s_axi.s_axi_bresp   = r_bresp;

  assign o_wr_en   = w_accept;
  assign o_wr_addr = s_axi.s_axi_awaddr;
  assign o_wr_data = s_axi.s_axi_wdata[63:0];
  assign o_wr_strb = s_axi.s_axi_wstrb[7:0];

  assign w_unused_bits = ^{s_axi.s_axi_wdata[DATA_WIDTH-1:64], s_axi.s_axi_wstrb[DATA_WIDTH/8-1:8]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= RESP_OKAY;
    end else if (w_accept) begin
      r_bvalid <= 1'b1;
      r_bid    <= s_axi.s_axi_awid;
      r_bresp  <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && s_axi.s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_boot_ctrl.sv
// Core boot sequencer: AXI-programmed boot address, start/abort commands,
// reset hold, run with timeout, sticky done/timeout status.
module axi4_boot_ctrl
  import boot_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic            aclk,
  input  logic            areset,
  axi4_boot_ctrl_if.slave s_axi,
  input  logic            core_done_i,
  output logic            core_rst_o,
  output logic            fetch_en_o,
  output logic [63:0]     boot_addr_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  localparam int CNT_W = $clog2(max_int(RST_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  boot_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic [63:0]      r_boot_addr;

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [63:0]           w_wr_data;
  logic [7:0]            w_wr_strb;
  logic                  w_wr_err;
  logic w_is_cmd, w_is_boot, w_is_abort, w_magic, w_busy;
  logic w_start, w_abort, w_boot_wr;

  axi4_boot_wr_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_wr_if (
    .aclk      (aclk),
    .areset    (areset),
    .s_axi     (s_axi),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err)
  );

  assign w_is_cmd   = (w_wr_addr == ADDR_WIDTH'(REG_CMD));
  assign w_is_boot  = (w_wr_addr == ADDR_WIDTH'(REG_BOOT_ADDR));
  assign w_is_abort = (w_wr_addr == ADDR_WIDTH'(REG_ABORT));
  assign w_magic    = (w_wr_data == START_MAGIC) && (w_wr_strb == START_STRB);
  assign w_busy     = (r_state == ST_RST_HOLD) || (r_state == ST_RUN);

  assign w_start   = w_wr_en & w_is_cmd & w_magic & ~w_busy;
  assign w_abort   = w_wr_en & w_is_abort;
  assign w_boot_wr = w_wr_en & w_is_boot & ~w_busy;
  assign w_wr_err  = ~(w_is_cmd | w_is_boot | w_is_abort)
                   | (w_is_cmd & w_magic & w_busy)
                   | (w_is_boot & w_busy);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_tmo       <= 1'b0;
      r_boot_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_boot_wr) r_boot_addr <= w_wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_tmo_nxt   = r_tmo;
    core_rst_o  = 1'b1;
    fetch_en_o  = 1'b0;
    busy_o      = 1'b0;
    // Abort outranks everything; a start can only arrive from IDLE or DONE.
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_tmo_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_RST_HOLD;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_tmo_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_RST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (core_done_i) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else if (r_cnt == TMO_LAST) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_tmo_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    case (r_state)
      ST_RST_HOLD: busy_o = 1'b1;
      ST_RUN: begin
        core_rst_o = 1'b0;
        fetch_en_o = 1'b1;
        busy_o     = 1'b1;
      end
      default: ;
    endcase
  end

  assign boot_addr_o = r_boot_addr;
  assign done_o      = r_done;
  assign timeout_o   = r_tmo;

endmodule

// File: tb/tb_axi4_boot_ctrl.sv
// Directed plus randomized bench for axi4_boot_ctrl against a cycle-time
// reference model of the boot sequence and the AXI write responses.
module tb_axi4_boot_ctrl;
  import boot_pkg::*;

  localparam int DW   = 512;
  localparam int AW   = 64;
  localparam int IW   = 4;
  localparam int RSTC = 16;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        areset;
  logic        core_done_i;
  logic        core_rst_o, fetch_en_o, busy_o, done_o, timeout_o;
  logic [63:0] boot_addr_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  axi4_boot_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi4_boot_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk        (clk),
    .areset      (areset),
    .s_axi       (bus),
    .core_done_i (core_done_i),
    .core_rst_o  (core_rst_o),
    .fetch_en_o  (fetch_en_o),
    .boot_addr_o (boot_addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus the cycle at which the boot was started.
  typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE} mph_e;
  mph_e          m_ph;
  int            m_t0;
  logic          m_done, m_tmo, m_bvalid, last_acc;
  logic [63:0]   m_boot;
  logic [IW-1:0] m_bid;
  logic [1:0]    m_bresp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_t0 = 0; m_done = 0; m_tmo = 0;
    m_bvalid = 0; m_bid = '0; m_bresp = 2'b00; m_boot = '0; last_acc = 0;
  endtask

  task automatic check_all();
    logic run, hold, rdy;
    run  = (m_ph == M_RUN);
    hold = (m_ph == M_HOLD);
    rdy  = bus.s_axi_awvalid && bus.s_axi_wvalid && !m_bvalid;
    chk("core_rst", core_rst_o, !run);
    chk("fetch_en", fetch_en_o, run);
    chk("busy", busy_o, run | hold);
    chk("done", done_o, m_done);
    chk("timeout", timeout_o, m_tmo);
    chk("boot_addr", boot_addr_o, m_boot);
    chk("bvalid", bus.s_axi_bvalid, m_bvalid);
    chk("awready", bus.s_axi_awready, rdy);
    chk("wready", bus.s_axi_wready, rdy);
    if (m_bvalid) begin
      chk("bid", bus.s_axi_bid, m_bid);
      chk("bresp", bus.s_axi_bresp, m_bresp);
    end
  endtask

  // One clock: capture inputs, advance the model across the edge, then check.
  task automatic tick();
    logic acc, busy, chg, dn, br;
    logic [63:0] a, d;
    logic [7:0] s;
    logic [IW-1:0] id;
    logic [1:0] r;
    acc  = bus.s_axi_awvalid && bus.s_axi_wvalid && !m_bvalid;
    a    = bus.s_axi_awaddr;
    d    = bus.s_axi_wdata[63:0];
    s    = bus.s_axi_wstrb[7:0];
    id   = bus.s_axi_awid;
    br   = bus.s_axi_bready;
    dn   = core_done_i;
    busy = (m_ph == M_HOLD) || (m_ph == M_RUN);
    @(posedge clk);
    cyc++;
    chg = 0;
    if (acc) begin
      r = 2'b00;
      acc_cyc = cyc;
      if (a == 64'h0) begin
        if (d == 64'hFFFF_FFFF_FFFF_FFFF && s == 8'hFF) begin
          if (busy) r = 2'b10;
          else begin m_ph = M_HOLD; m_t0 = cyc; m_done = 0; m_tmo = 0; chg = 1; end
        end
      end else if (a == 64'h8) begin
        if (busy) r = 2'b10; else m_boot = d;
      end else if (a == 64'h10) begin
        m_ph = M_IDLE; m_done = 0; m_tmo = 0; chg = 1;
      end else r = 2'b10;
      m_bvalid = 1; m_bid = id; m_bresp = r;
    end else if (m_bvalid && br) m_bvalid = 0;
    if (!chg) begin
      if (m_ph == M_HOLD) begin
        if (cyc - m_t0 == RSTC) m_ph = M_RUN;
      end else if (m_ph == M_RUN) begin
        if (dn) begin m_ph = M_DONE; m_done = 1; end
        else if (cyc - m_t0 - RSTC == TMO) begin m_ph = M_DONE; m_done = 1; m_tmo = 1; end
      end
    end
    last_acc = acc;
    #1;
    check_all();
  endtask

  task automatic drive_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    bus.s_axi_awid       = IW'($urandom);
    bus.s_axi_awaddr     = addr;
    bus.s_axi_wdata      = {16{$urandom}};
    bus.s_axi_wdata[63:0] = data;
    bus.s_axi_wstrb      = {2{$urandom}};
    bus.s_axi_wstrb[7:0] = strb;
    bus.s_axi_awvalid    = 1'b1;
    bus.s_axi_wvalid     = 1'b1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           output logic [1:0] resp);
    int n;
    drive_write(addr, data, strb);
    bus.s_axi_bready = 1'b1;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < 20) begin tick(); n++; end
    if (!last_acc) chk("write_accept_timeout", 0, 1);
    resp = bus.s_axi_bresp;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    tick();
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (fetch_en_o !== 1'b1 && n < 40) begin tick(); n++; end
    chk("reach_run", fetch_en_o, 1);
  endtask

  initial begin
    logic [1:0] r;
    int n, s_acc, sel;
    logic [63:0] addr, data;

    areset = 1'b1; core_done_i = 1'b0;
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("bid_rst", bus.s_axi_bid, 0);
    chk("bresp_rst", bus.s_axi_bresp, 0);
    @(negedge clk);
    areset = 1'b0;

    // Boot address then start; reset hold length and run outputs.
    axi_write(64'h8, 64'h8000_0000, 8'hFF, r);
    chk("boot_wr_resp", r, RESP_OKAY);
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("start_resp", r, RESP_OKAY);
    s_acc = acc_cyc;
    n = 0;
    while (core_rst_o !== 1'b0 && n < 40) begin tick(); n++; end
    chk("rst_hold_len", cyc - s_acc, RSTC);
    chk("fetch_en_run", fetch_en_o, 1);
    chk("boot_addr_run", boot_addr_o, 64'h8000_0000);

    // core_done pulse after 50 run cycles.
    repeat (50) tick();
    core_done_i = 1'b1; tick(); core_done_i = 1'b0;
    chk("done_pulse_done", done_o, 1);
    chk("done_pulse_tmo", timeout_o, 0);
    chk("done_pulse_rst", core_rst_o, 1);

    // Timeout with no core_done.
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("restart_resp", r, RESP_OKAY);
    chk("done_cleared", done_o, 0);
    s_acc = acc_cyc;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin tick(); n++; end
    chk("timeout_run_len", cyc - s_acc - RSTC, TMO);
    chk("timeout_flag", timeout_o, 1);

    // core_done on the last run cycle beats the timeout.
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    s_acc = acc_cyc;
    chk("timeout_cleared", timeout_o, 0);
    n = 0;
    while ((cyc - s_acc) < RSTC + TMO - 1 && n < 200) begin tick(); n++; end
    core_done_i = 1'b1; tick(); core_done_i = 1'b0;
    chk("coincide_done", done_o, 1);
    chk("coincide_tmo", timeout_o, 0);
    chk("coincide_cyc", cyc - s_acc, RSTC + TMO);

    // Writes rejected while running, and an unmapped address.
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    wait_run();
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("start_in_run", r, RESP_SLVERR);
    chk("still_run", fetch_en_o, 1);
    axi_write(64'h18, 64'h0123, 8'hFF, r);
    chk("bad_addr", r, RESP_SLVERR);
    axi_write(64'h8, 64'h1234, 8'hFF, r);
    chk("boot_busy", r, RESP_SLVERR);
    chk("boot_busy_kept", boot_addr_o, 64'h8000_0000);

    // Back-pressured response with a second write waiting behind it.
    drive_write(64'h0, 64'h0, 8'hFF);
    bus.s_axi_awid = 4'h9;
    bus.s_axi_bready = 1'b0;
    n = 0; last_acc = 0;
    while (!last_acc && n < 20) begin tick(); n++; end
    bus.s_axi_awid = 4'h3;
    repeat (10) begin
      tick();
      chk("bvalid_hold", bus.s_axi_bvalid, 1);
      chk("bid_hold", bus.s_axi_bid, 4'h9);
      chk("awready_hold", bus.s_axi_awready, 0);
    end
    bus.s_axi_bready = 1'b1;
    tick();
    n = 0; last_acc = 0;
    while (!last_acc && n < 20) begin tick(); n++; end
    chk("second_bid", bus.s_axi_bid, 4'h3);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    tick();

    // Abort from whatever state, then abort during reset hold.
    axi_write(64'h10, 64'h5, 8'h01, r);
    chk("abort_resp", r, RESP_OKAY);
    chk("abort_idle", busy_o, 0);
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    s_acc = acc_cyc;
    chk("hold_busy", busy_o, 1);
    axi_write(64'h10, 64'h0, 8'h00, r);
    chk("abort_in_hold", (acc_cyc - s_acc) < RSTC, 1);
    chk("abort_hold_idle", busy_o, 0);
    chk("abort_hold_rst", core_rst_o, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!bus.s_axi_awvalid && $urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 19);
        if (sel < 8) addr = 64'h0;
        else if (sel < 13) addr = 64'h8;
        else if (sel == 13) addr = 64'h10;
        else if (sel < 17) addr = 64'h18;
        else addr = {$urandom, $urandom};
        data = ($urandom_range(0, 9) < 6) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        drive_write(addr, data, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF);
      end
      bus.s_axi_bready = ($urandom_range(0, 3) != 0);
      core_done_i = ($urandom_range(0, 29) == 0);
      tick();
      if (last_acc) begin bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; end
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    core_done_i = 1'b0; bus.s_axi_bready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset while running with a response pending.
    axi_write(64'h10, 64'h0, 8'hFF, r);
    axi_write(64'h8, 64'hABCD_0000, 8'hFF, r);
    axi_write(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    wait_run();
    drive_write(64'h0, 64'h0, 8'hFF);
    bus.s_axi_bready = 1'b0;
    n = 0; last_acc = 0;
    while (!last_acc && n < 20) begin tick(); n++; end
    #2 areset = 1'b1;
    #1;
    chk("arst_core_rst", core_rst_o, 1);
    chk("arst_fetch", fetch_en_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_tmo", timeout_o, 0);
    chk("arst_boot", boot_addr_o, 0);
    chk("arst_bvalid", bus.s_axi_bvalid, 0);
    chk("arst_awready", bus.s_axi_awready, 0);
    chk("arst_bid", bus.s_axi_bid, 0);
    chk("arst_bresp", bus.s_axi_bresp, 0);
    model_reset();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
